prf_freelist: RTL and testbench
===============================

# prf_freelist

Physical-register free-list manager that owns allocation and release of PRF entries for the rename stage. It holds free physical register ids in a circular buffer. It hands out one id per cycle to rename, takes back one id per cycle from retire, and keeps a committed copy of the allocation pointer so a pipeline flush restores the speculative allocations in one cycle. It replaces the simple increment-counter allocator and allows out-of-order release ids.

## Interface
- NPREG, 32: number of physical registers; power of two, ≥ 4.
- PREG_ID_BITS, $clog2(NPREG): physical register id width.
- clk  in  1  clock.
- rstn  in  1  reset: synchronous, active-low (rstn); clock clk.
- alloc_req_i  in  1  rename requests one physical register this cycle.
- alloc_valid_o  out  1  a free id is available on alloc_preg_o.
- alloc_preg_o  out  PREG_ID_BITS  id handed out when alloc_req_i && alloc_valid_o.
- commit_alloc_i  in  1  oldest allocating instruction retired; its allocation becomes non-speculative.
- free_valid_i  in  1  retire releases a physical register.
- free_preg_i  in  PREG_ID_BITS  id being released.
- flush_i  in  1  squash all speculative (uncommitted) allocations.
- free_count_o  out  PREG_ID_BITS+1  number of ids allocatable by rename (tail − spec_head).
- err_o  out  1  sticky protocol-error flag.

## Operation
- Storage: fl[NPREG] of preg ids. Pointers spec_head, commit_head and tail are PREG_ID_BITS+1 bits wide. The MSB is the wrap bit and the low bits are the index. All pointer arithmetic is modulo 2·NPREG.
- Reset: fl[i]=i, spec_head=commit_head=0, tail=NPREG (wrap bit 1, index 0). The list starts full, with all ids free.
- alloc_valid_o = (free_count_o != 0) && !flush_i. alloc_preg_o = fl[spec_head index].
- Allocate fires when alloc_req_i && alloc_valid_o. It sets spec_head += 1. alloc_req_i while !alloc_valid_o has no effect; the requester must hold or retry it.
- Free fires on free_valid_i. It writes fl[tail index] = free_preg_i and sets tail += 1.
- Commit fires on commit_alloc_i. It sets commit_head += 1.
- Flush sets spec_head = the commit_head value after this cycle's commit update. Any allocate in the same cycle is blocked, because alloc_valid_o is low.
- Free and commit in the same cycle as a flush are both applied.
- Allocate and free in the same cycle are both applied. When the list holds exactly 1 id, the allocate gets the old head id and the freed id lands at tail.
- When free_count_o==0, a same-cycle free does not bypass to the allocate output. There is no 0-cycle release-to-allocate path; the freed id becomes available next cycle.
- Errors set err_o=1, which stays 1 until reset:
  - Free while tail − commit_head == NPREG (overflow): the free is dropped.
  - Commit while commit_head == spec_head, with no speculative allocation outstanding: the commit is dropped.
  - No other state changes in either error case.
- Simulation-only: an assertion fires when free_preg_i equals an id currently in the free region.
- Reset mid-operation returns every register to its reset value in the next cycle, regardless of other inputs.

## Timing
- alloc_valid_o, alloc_preg_o and free_count_o are functions of registered state and flush_i only. There is no combinational path from alloc_req_i, free_valid_i or commit_alloc_i.
- Back-to-back allocation: one id per cycle, consecutive list entries.
- Allocate→count: free_count_o reflects an allocate or free one cycle after the edge at which it fires.
- Free→allocatable: a freed id becomes visible on alloc_preg_o no earlier than the cycle after the free, and only once spec_head reaches it.
- Flush→recovered: the restored head and count appear one cycle after flush_i. alloc_valid_o is low during the flush cycle.
- Reset values:
  - alloc_valid_o=1
  - alloc_preg_o=0
  - free_count_o=NPREG
  - err_o=0

## Test plan
- Reset, then alloc_req_i for 3 cycles → alloc_preg_o 0,1,2 on successive cycles; free_count_o 32→29; err_o=0.
- 32 consecutive allocs → alloc_valid_o=0, free_count_o=0; extra alloc_req_i leaves state unchanged. Then free preg 7 → next cycle alloc_valid_o=1, alloc_preg_o=7, free_count_o=1.
- Alloc 0..4, commit_alloc_i twice, then flush_i → cycle after flush alloc_preg_o=2, free_count_o=30; alloc_valid_o=0 during the flush cycle.
- free_count_o=1 (head id 31): alloc_req_i and free_valid_i (preg 3) in the same cycle → granted 31; next cycle alloc_preg_o=3, free_count_o=1.
- Free immediately after reset (list full) → err_o=1 and stays 1; free_count_o stays 32. Commit with no outstanding allocation also sets err_o.
- Random alloc/free/commit/flush traffic against a reference model → every id is held by exactly one owner and is never duplicated, and free_count_o always matches the model.

Source files
------------

// File: rtl/prf_freelist.sv
`default_nettype none
// prf_freelist: circular free list of physical register ids with a speculative
// and a committed allocation head; a flush rewinds speculative allocations.
module prf_freelist #(
   parameter int NPREG        = 32,
   parameter int PREG_ID_BITS = $clog2(NPREG)
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    alloc_req_i,
   output logic                    alloc_valid_o,
   output logic [PREG_ID_BITS-1:0] alloc_preg_o,
   input  logic                    commit_alloc_i,
   input  logic                    free_valid_i,
   input  logic [PREG_ID_BITS-1:0] free_preg_i,
   input  logic                    flush_i,
   output logic [PREG_ID_BITS:0]   free_count_o,
   output logic                    err_o
);
   localparam int PTR_W = PREG_ID_BITS + 1;

   logic [PREG_ID_BITS-1:0] fl [NPREG];
   logic [PTR_W-1:0]        spec_head;
   logic [PTR_W-1:0]        commit_head;
   logic [PTR_W-1:0]        tail;
   logic [PTR_W-1:0]        spec_head_nxt;
   logic [PTR_W-1:0]        commit_head_nxt;
   logic [PTR_W-1:0]        tail_nxt;
   logic [PTR_W-1:0]        listed;
   logic                    alloc_fire;
   logic                    free_fire;
   logic                    commit_fire;
   logic                    overflow;
   logic                    commit_err;
   logic                    err;

   assign free_count_o  = tail - spec_head;
   assign alloc_valid_o = (free_count_o != '0) && !flush_i;
   assign alloc_preg_o  = fl[spec_head[PREG_ID_BITS-1:0]];

   // Speculatively allocated ids still occupy slots, so the list is full when
   // everything from commit_head to tail covers all NPREG slots.
   assign listed      = tail - commit_head;
   assign overflow    = free_valid_i && (listed == PTR_W'(NPREG));
   assign commit_err  = commit_alloc_i && (commit_head == spec_head);
   assign alloc_fire  = alloc_req_i && alloc_valid_o;
   assign free_fire   = free_valid_i && !overflow;
   assign commit_fire = commit_alloc_i && !commit_err;
   assign err_o       = err;

   always_comb begin
      commit_head_nxt = commit_head + PTR_W'(commit_fire);
      tail_nxt        = tail + PTR_W'(free_fire);
      spec_head_nxt   = flush_i ? commit_head_nxt : (spec_head + PTR_W'(alloc_fire));
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         spec_head   <= '0;
         commit_head <= '0;
         tail        <= PTR_W'(NPREG);
         err         <= 1'b0;
         for (int i = 0; i < NPREG; i++) begin
            fl[i] <= PREG_ID_BITS'(i);
         end
      end else begin
         spec_head   <= spec_head_nxt;
         commit_head <= commit_head_nxt;
         tail        <= tail_nxt;
         err         <= err | overflow | commit_err;
         if (free_fire) begin
            fl[tail[PREG_ID_BITS-1:0]] <= free_preg_i;
         end
      end
   end

`ifndef SYNTHESIS
   logic             dup_free;
   logic [PTR_W-1:0] scan_ptr;

   always_comb begin
      dup_free = 1'b0;
      scan_ptr = '0;
      for (int i = 0; i < NPREG; i++) begin
         scan_ptr = spec_head + PTR_W'(i);
         if ((PTR_W'(i) < free_count_o) && (fl[scan_ptr[PREG_ID_BITS-1:0]] == free_preg_i)) begin
            dup_free = 1'b1;
         end
      end
   end

   // A dropped overflow free is already reported through err_o.
   always_ff @(posedge clk) begin
      if (rstn && free_valid_i && !overflow) begin
         assert (!dup_free) else $error("prf_freelist: released id %0d is already free", free_preg_i);
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_prf_freelist.sv
`default_nettype none
// tb_prf_freelist: directed scenarios plus random traffic checked against a
// queue-based model of free, speculative and committed id ownership.
module tb_prf_freelist;
   localparam int NPREG = 32;
   localparam int IDW   = $clog2(NPREG);

   logic           clk = 1'b0;
   logic           rstn = 1'b0;
   logic           alloc_req_i = 1'b0;
   logic           alloc_valid_o;
   logic [IDW-1:0] alloc_preg_o;
   logic           commit_alloc_i = 1'b0;
   logic           free_valid_i = 1'b0;
   logic [IDW-1:0] free_preg_i = '0;
   logic           flush_i = 1'b0;
   logic [IDW:0]   free_count_o;
   logic           err_o;

   int checks = 0;
   int errors = 0;

   // Model: allocatable ids in order, uncommitted allocations in order, and
   // ids held by retired instructions (the only ones the bench may release).
   int free_q[$];
   int spec_q[$];
   int pool[$];
   bit err_m;

   prf_freelist #(.NPREG(NPREG)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .alloc_req_i    (alloc_req_i),
      .alloc_valid_o  (alloc_valid_o),
      .alloc_preg_o   (alloc_preg_o),
      .commit_alloc_i (commit_alloc_i),
      .free_valid_i   (free_valid_i),
      .free_preg_i    (free_preg_i),
      .flush_i        (flush_i),
      .free_count_o   (free_count_o),
      .err_o          (err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      free_q.delete();
      spec_q.delete();
      pool.delete();
      for (int i = 0; i < NPREG; i++) free_q.push_back(i);
      err_m = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      alloc_req_i = 1'b0;
      free_valid_i = 1'b0;
      commit_alloc_i = 1'b0;
      flush_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      model_reset();
   endtask

   // One clock: drive, check outputs against the model, clock, advance model.
   task automatic step(input bit req, input bit fv, input int fid, input bit cm, input bit fl);
      bit valid_m;
      bit ovf;
      bit cerr;
      @(negedge clk);
      alloc_req_i    = req;
      free_valid_i   = fv;
      free_preg_i    = fid[IDW-1:0];
      commit_alloc_i = cm;
      flush_i        = fl;
      #1;
      valid_m = (free_q.size() != 0) && !fl;
      chk("alloc_valid", 32'(alloc_valid_o), 32'(valid_m));
      if (valid_m) chk("alloc_preg", 32'(alloc_preg_o), free_q[0]);
      chk("free_count", 32'(free_count_o), free_q.size());
      chk("err", 32'(err_o), 32'(err_m));
      @(posedge clk);
      ovf  = fv && ((spec_q.size() + free_q.size()) == NPREG);
      cerr = cm && (spec_q.size() == 0);
      if (ovf || cerr) err_m = 1'b1;
      if (cm && !cerr) pool.push_back(spec_q.pop_front());
      if (req && valid_m) spec_q.push_back(free_q.pop_front());
      if (fv && !ovf) begin
         for (int k = 0; k < pool.size(); k++) begin
            if (pool[k] == fid) begin
               pool.delete(k);
               break;
            end
         end
         free_q.push_back(fid);
      end
      if (fl) begin
         while (spec_q.size() != 0) free_q.push_front(spec_q.pop_back());
      end
   endtask

   initial begin
      int fid;
      bit fv;
      bit cm;
      model_reset();

      // Three allocations straight out of reset: ids 0,1,2, count 32 -> 29.
      do_reset();
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("count_after3", 32'(free_count_o), 29);

      // Drain the list, hammer an empty list, commit a few, free id 7.
      do_reset();
      for (int i = 0; i < NPREG; i++) step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);
      step(0, 1, 7, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("refill_preg", 32'(alloc_preg_o), 7);
      chk("refill_count", 32'(free_count_o), 1);

      // Allocate 0..4, commit two, flush: head rewinds to id 2, count 30.
      do_reset();
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      chk("flush_preg", 32'(alloc_preg_o), 2);
      chk("flush_count", 32'(free_count_o), 30);

      // Single free id (31) allocated while id 3 is released in the same cycle.
      do_reset();
      for (int i = 0; i < NPREG - 1; i++) step(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
      step(1, 1, 3, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("swap_preg", 32'(alloc_preg_o), 3);
      chk("swap_count", 32'(free_count_o), 1);

      // Overflow free on a full list, then a commit with nothing outstanding.
      do_reset();
      step(0, 1, 5, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("ovf_count", 32'(free_count_o), NPREG);
      do_reset();
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      chk("cerr_sticky", 32'(err_o), 1);

      // Reset in the middle of traffic.
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      do_reset();
      step(0, 0, 0, 0, 0);

      // Random legal traffic: only retired ids are released.
      for (int n = 0; n < 3000; n++) begin
         cm  = (spec_q.size() != 0) && ($urandom_range(0, 2) == 0);
         fv  = (pool.size() != 0) && ($urandom_range(0, 2) != 0);
         fid = fv ? pool[$urandom_range(0, pool.size() - 1)] : 0;
         step($urandom_range(0, 3) != 0, fv, fid, cm, $urandom_range(0, 40) == 0);
      end
      step(0, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
